// File: rtl/seg_scan_display_if.sv
// Display-stage bus: counter value in, multiplexed 7-segment drive and busy flag out.
interface seg_scan_display_if;
  logic [7:0] value;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  modport master (output value, input an, seg, dp, busy);
  modport slave  (input value, output an, seg, dp, busy);
endinterface

// File: rtl/seg_scan_display.sv
// Samples the counter value, converts it to BCD by shift-add-3, and scans
// hundreds/tens/ones onto a 4-digit common-anode display with leading-zero blanking.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_display_if.slave   bus
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  value_q;
  logic [7:0]  last_value;
  logic [19:0] sr;
  logic [19:0] sr_adj;
  logic [3:0]  bit_cnt;
  logic [3:0]  hund, tens, ones;
  logic        busy_r;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    an_r, an_next;
  logic [6:0]    seg_r, seg_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Hundreds nibble never exceeds 2, so its carry-out on the shift is always zero.
  always_comb begin
    sr_adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      value_q    <= '0;
      last_value <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      hund       <= '0;
      tens       <= '0;
      ones       <= '0;
      busy_r     <= 1'b0;
    end else begin
      value_q <= bus.value;
      case (state)
        IDLE: begin
          if (value_q != last_value) begin
            sr         <= {12'b0, value_q};
            last_value <= value_q;
            bit_cnt    <= 4'd8;
            busy_r     <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sr      <= sr_adj << 1;
          bit_cnt <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd1) state <= DONE;
        end
        DONE: begin
          hund   <= sr[19:16];
          tens   <= sr[15:12];
          ones   <= sr[11:8];
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'b1111111;
    case (idx)
      2'd0: begin
        an_next  = 4'b1110;
        seg_next = enc(ones);
      end
      2'd1: begin
        an_next  = 4'b1101;
        seg_next = (hund == 4'd0 && tens == 4'd0) ? 7'b1111111 : enc(tens);
      end
      2'd2: begin
        an_next  = 4'b1011;
        seg_next = (hund == 4'd0) ? 7'b1111111 : enc(hund);
      end
      default: begin
        an_next  = 4'b0111;
        seg_next = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      an_r  <= '1;
      seg_r <= '1;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      an_r  <= an_next;
      seg_r <= seg_next;
    end
  end

  assign bus.an   = an_r;
  assign bus.seg  = seg_r;
  assign bus.dp   = 1'b1;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized scoreboard bench for seg_scan_display: stimulus queues expected
// conversions, a monitor checks busy, latency and every scanned an/seg cycle.
module tb_seg_scan_display;

  localparam int unsigned SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s;
  always #5 clk = ~clk;

  seg_scan_display_if bus();

  seg_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned v;
    int unsigned t0;
    bit          chained;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned v, input int unsigned slot);
    int unsigned h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (slot)
      0: return seg_of(o);
      1: return (h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
      2: return (h == 0) ? 7'b1111111 : seg_of(h);
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int unsigned slot);
    case (slot)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Monitor: displayed value follows a conversion one cycle after busy falls.
  initial begin
    int unsigned n = 0, disp_v = 0, pend_v = 0, busy_len = 0, last_done = 0, slot = 0;
    bit pend = 0, busy_prev = 0;
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_s) begin
        check("reset_an", {28'd0, bus.an}, 32'hF);
        check("reset_seg", {25'd0, bus.seg}, 32'h7F);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_dp", {31'd0, bus.dp}, 32'd1);
        n = 0; disp_v = 0; pend = 0; busy_prev = 0; busy_len = 0;
      end else begin
        n++;
        if (pend) begin
          disp_v = pend_v;
          pend   = 0;
        end
        slot = ((n - 1) / SCAN_DIV) % 4;
        check("scan_an", {28'd0, bus.an}, {28'd0, exp_an(slot)});
        check("scan_seg", {25'd0, bus.seg}, {25'd0, exp_seg(disp_v, slot)});
        check("dp_off", {31'd0, bus.dp}, 32'd1);
        if (bus.busy === 1'b1) begin
          if (!busy_prev) check("busy_rise_expected", {31'd0, sb_q.size() != 0}, 32'd1);
          busy_len++;
        end else if (busy_prev) begin
          check("busy_len", busy_len, 32'd9);
          busy_len = 0;
          check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.chained) check("latency_chained", cyc - last_done, 32'd10);
            else           check("latency", cyc - e.t0, 32'd11);
            pend_v = e.v;
            pend   = 1;
          end
          last_done = cyc;
        end
        busy_prev = (bus.busy === 1'b1);
      end
    end
  end

  task automatic drive(input int unsigned v, input bit chained = 1'b0);
    @(posedge clk);
    #2;
    bus.value = v[7:0];
    if (v != last_acc) begin
      sb_q.push_back('{v, cyc, chained});
      last_acc = v;
    end
  endtask

  task automatic wait_idle(input int unsigned budget, input int unsigned hold);
    int unsigned k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL conv_timeout: %0d entries pending, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (hold) @(posedge clk);
  endtask

  initial begin
    bus.value = 8'd0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    last_acc = 0;
    repeat (24) @(posedge clk);

    drive(25);  wait_idle(40, 24);
    drive(0);   wait_idle(40, 24);
    drive(255); wait_idle(40, 24);
    drive(3);   wait_idle(40, 24);

    // 7 then 8 during the third shift: both conversions must complete in order.
    drive(7);
    repeat (3) @(posedge clk);
    drive(8, 1'b1);
    wait_idle(60, 24);

    // Reset pulse mid-conversion of 19; the same value is reconverted afterwards.
    drive(19);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    sb_q.delete();
    last_acc = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    if (32'(bus.value) != last_acc) begin
      sb_q.push_back('{32'(bus.value), cyc, 1'b0});
      last_acc = 32'(bus.value);
    end
    wait_idle(40, 24);

    for (int i = 0; i < 14; i++) begin
      int unsigned v;
      v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 25) : $urandom_range(0, 255);
      drive(v);
      wait_idle(40, $urandom_range(18, 40));
    end

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
